event_capture_core: RTL and testbench

Capture engine feeding the bus-facing register block of the event monitor. Each cycle it evaluates the probe bus against the programmed trigger (value, mask, mode). On a qualified hit it pushes a {timestamp, event ID, probe} record into an internal first-word-fall-through FIFO. The register block drains that FIFO over the bus; this block also reports the FIFO status and sticky flags back to it.

---
 rtl/event_capture_core.sv | 121 ++++++++++++
 tb/tb_event_capture_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_capture_core.sv
// Probe trigger evaluation and capture of {timestamp, id, probe} records into a
// first-word-fall-through FIFO drained by the register block.
module event_capture_core #(
    parameter int unsigned PROBE_W    = 32,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PROBE_W-1:0]               probe,
    input  logic                             en,
    input  logic                             arm,
    input  logic [1:0]                       trig_mode,
    input  logic [PROBE_W-1:0]               trig_value,
    input  logic [PROBE_W-1:0]               trig_mask,
    input  logic                             clear_sticky,
    input  logic                             evt_pop,
    output logic [TS_W+ID_W+PROBE_W-1:0]     evt_data,
    output logic                             evt_valid,
    output logic                             fifo_empty,
    output logic                             fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             triggered_sticky,
    output logic                             fifo_overflow_sticky
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned EW = TS_W + ID_W + PROBE_W;

    logic [PROBE_W-1:0] probe_q;
    logic               match_q;
    logic [TS_W-1:0]    ts_q;
    logic [ID_W-1:0]    id_q;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               trig_q, trig_d;
    logic               ovf_q, ovf_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];

    logic match, hit, cap, pop, push, drop, full, empty;

    assign match = ((probe ^ trig_value) & trig_mask) == '0;

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            2'd0:    hit = match;
            2'd1:    hit = match && !match_q;
            2'd2:    hit = ((probe ^ probe_q) & trig_mask) != '0;
            default: hit = 1'b0;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign cap   = en && arm && hit;
    // A pop on an empty FIFO is ignored, so a push into empty never pairs with a pop.
    assign pop   = evt_pop && !empty;
    assign push  = cap && (!full || pop);
    assign drop  = cap && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Set wins over clear so a hit coinciding with clear_sticky is never lost.
    assign trig_d = cap  ? 1'b1 : (clear_sticky ? 1'b0 : trig_q);
    assign ovf_d  = drop ? 1'b1 : (clear_sticky ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            probe_q  <= '0;
            match_q  <= 1'b0;
            ts_q     <= '0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            probe_q <= probe;
            match_q <= match;
            if (en) begin
                ts_q <= ts_q + TS_W'(1);
            end
            if (push) begin
                id_q     <= id_q + ID_W'(1);
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            trig_q  <= trig_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, id_q, probe};
        end
    end

    assign fifo_empty           = empty;
    assign fifo_full            = full;
    assign evt_valid            = !empty;
    assign fifo_count           = count_q;
    assign evt_data             = empty ? '0 : mem_q[rd_ptr_q];
    assign triggered_sticky     = trig_q;
    assign fifo_overflow_sticky = ovf_q;

endmodule

// File: tb/tb_event_capture_core.sv
// Directed bench for event_capture_core with a queue scoreboard of expected FIFO records.
module tb_event_capture_core;

    localparam int unsigned PROBE_W    = 32;
    localparam int unsigned ID_W       = 8;
    localparam int unsigned TS_W       = 32;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned EW         = TS_W + ID_W + PROBE_W;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH+1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PROBE_W-1:0] probe;
    logic               en, arm;
    logic [1:0]         trig_mode;
    logic [PROBE_W-1:0] trig_value, trig_mask;
    logic               clear_sticky, evt_pop;
    logic [EW-1:0]      evt_data;
    logic               evt_valid, fifo_empty, fifo_full;
    logic [CW-1:0]      fifo_count;
    logic               triggered_sticky, fifo_overflow_sticky;

    event_capture_core #(
        .PROBE_W   (PROBE_W),
        .ID_W      (ID_W),
        .TS_W      (TS_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .probe               (probe),
        .en                  (en),
        .arm                 (arm),
        .trig_mode           (trig_mode),
        .trig_value          (trig_value),
        .trig_mask           (trig_mask),
        .clear_sticky        (clear_sticky),
        .evt_pop             (evt_pop),
        .evt_data            (evt_data),
        .evt_valid           (evt_valid),
        .fifo_empty          (fifo_empty),
        .fifo_full           (fifo_full),
        .fifo_count          (fifo_count),
        .triggered_sticky    (triggered_sticky),
        .fifo_overflow_sticky(fifo_overflow_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state, updated from the inputs applied in each cycle.
    logic [EW-1:0]      exp_q[$];
    logic [TS_W-1:0]    m_ts;
    logic [ID_W-1:0]    m_id;
    logic [PROBE_W-1:0] m_probe_q;
    logic               m_match_q, m_trig, m_ovf;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ID_W-1:0] id_of(input logic [EW-1:0] d);
        return d[PROBE_W +: ID_W];
    endfunction

    function automatic logic [TS_W-1:0] ts_of(input logic [EW-1:0] d);
        return d[PROBE_W+ID_W +: TS_W];
    endfunction

    // One clock: evaluate the reference on the current inputs, clock the DUT, check status.
    task automatic tick();
        logic          m_match, m_hit, m_cap, m_pop, m_full, m_push;
        logic [EW-1:0] head;
        if (!rst_n) begin
            exp_q.delete();
            m_ts = '0; m_id = '0; m_probe_q = '0; m_match_q = 1'b0;
            m_trig = 1'b0; m_ovf = 1'b0;
        end else begin
            m_match = ((probe ^ trig_value) & trig_mask) == '0;
            case (trig_mode)
                2'd0:    m_hit = m_match;
                2'd1:    m_hit = m_match && !m_match_q;
                2'd2:    m_hit = ((probe ^ m_probe_q) & trig_mask) != '0;
                default: m_hit = 1'b0;
            endcase
            m_cap  = en && arm && m_hit;
            m_pop  = evt_pop && (exp_q.size() != 0);
            m_full = (exp_q.size() == FIFO_DEPTH);
            m_push = m_cap && (!m_full || m_pop);
            if (m_pop) begin
                head = exp_q.pop_front();
                chk("sb_head", evt_data, head);
            end
            if (m_push) begin
                exp_q.push_back({m_ts, m_id, probe});
                m_id = m_id + 1'b1;
            end
            if (m_cap) m_trig = 1'b1;
            else if (clear_sticky) m_trig = 1'b0;
            if (m_cap && m_full && !m_pop) m_ovf = 1'b1;
            else if (clear_sticky) m_ovf = 1'b0;
            m_probe_q = probe;
            m_match_q = m_match;
            if (en) m_ts = m_ts + 1'b1;
        end
        @(posedge clk);
        #1;
        chk("count", fifo_count, exp_q.size());
        chk("valid", evt_valid, exp_q.size() != 0);
        chk("empty", fifo_empty, exp_q.size() == 0);
        chk("full", fifo_full, exp_q.size() == FIFO_DEPTH);
        chk("trig_sticky", triggered_sticky, m_trig);
        chk("ovf_sticky", fifo_overflow_sticky, m_ovf);
    endtask

    logic [TS_W-1:0] ts_hold;
    logic            saw_wrap;
    int              prev_id;
    int              pid;

    initial begin
        rst_n = 1'b0; probe = '0; en = 1'b0; arm = 1'b0; trig_mode = 2'd3;
        trig_value = '0; trig_mask = '0; clear_sticky = 1'b0; evt_pop = 1'b0;
        tick();
        tick();
        chk("rst_data", evt_data, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;

        // Level trigger: idle 10 cycles so the first hit lands at ts = 10.
        en = 1'b1; arm = 1'b1;
        repeat (10) tick();
        trig_mode = 2'd0; trig_mask = 'hFF; trig_value = 'h5A; probe = 'h5A;
        chk("lvl_pre_valid", evt_valid, 0);
        tick();
        chk("lvl_valid_rise", evt_valid, 1);
        tick();
        tick();
        probe = '0;
        chk("lvl_count", fifo_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("lvl_probe", evt_data[PROBE_W-1:0], 'h5A);
            chk("lvl_id", id_of(evt_data), i);
            chk("lvl_ts", ts_of(evt_data), 10 + i);
            evt_pop = 1'b1;
            tick();
        end
        evt_pop = 1'b0;
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        chk("clr_trig", triggered_sticky, 0);

        // Rising match: held match yields one hit, re-entry yields a second.
        trig_mode = 2'd1; trig_value = 'h33; probe = '0;
        tick();
        probe = 'h33;
        repeat (5) tick();
        probe = '0;
        repeat (2) tick();
        probe = 'h33;
        repeat (2) tick();
        probe = '0;
        tick();
        chk("rise_count", fifo_count, 2);
        chk("rise_trig", triggered_sticky, 1);
        evt_pop = 1'b1;
        repeat (2) tick();
        evt_pop = 1'b0;

        // Overflow from a fresh reset so stored IDs are 0..15.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        trig_mode = 2'd0; trig_mask = '0;
        repeat (20) tick();
        chk("ovf_count", fifo_count, 16);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", fifo_overflow_sticky, 1);
        trig_mode = 2'd3; clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        chk("clr2_trig", triggered_sticky, 0);
        chk("clr2_ovf", fifo_overflow_sticky, 0);

        // Full FIFO with hit and pop together: count holds, no drop.
        chk("bnd_head0", id_of(evt_data), 0);
        trig_mode = 2'd0; evt_pop = 1'b1;
        tick();
        evt_pop = 1'b0; trig_mode = 2'd3;
        chk("bnd_count", fifo_count, 16);
        chk("bnd_ovf", fifo_overflow_sticky, 0);
        chk("bnd_head1", id_of(evt_data), 1);
        for (int i = 0; i < 16; i++) begin
            chk("bnd_drain_id", id_of(evt_data), i + 1);
            evt_pop = 1'b1;
            tick();
        end
        evt_pop = 1'b0;
        chk("bnd_empty", fifo_empty, 1);

        // Disable: timestamp freezes, no pushes, pops still drain.
        trig_mode = 2'd0;
        repeat (3) tick();
        en = 1'b0; evt_pop = 1'b1;
        ts_hold = m_ts;
        repeat (5) tick();
        chk("dis_count", fifo_count, 0);
        chk("dis_empty", fifo_empty, 1);
        evt_pop = 1'b0; en = 1'b1;
        tick();
        chk("dis_ts_frozen", ts_of(evt_data), ts_hold);
        evt_pop = 1'b1; trig_mode = 2'd3;
        tick();

        // ID wrap: 257 pushes while draining.
        trig_mode = 2'd0;
        saw_wrap = 1'b0;
        prev_id = -1;
        for (int i = 0; i < 257; i++) begin
            if (evt_valid) begin
                pid = int'(id_of(evt_data));
                if (prev_id == 255 && pid == 0) saw_wrap = 1'b1;
                prev_id = pid;
            end
            tick();
        end
        trig_mode = 2'd3;
        tick();
        evt_pop = 1'b0;
        chk("wrap_seen", saw_wrap, 1);
        chk("wrap_empty", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
